// File: rtl/inv_resp_checker.sv
// Response checker for the inv cell: after each stimulus transition, wait a
// settle window, then confirm that Z is the complement of A. Results feed saturating counters.
module inv_resp_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             stim_a,
    input  logic             dut_z,
    output logic             busy,
    output logic             err_pulse,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass
);

    localparam int             CW       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          z_meta;
    logic          z_s;
    logic          stim_q;
    logic          stim_edge;
    logic          mismatch;

    // stim_q tracks stim_a even while disabled, so re-enabling never sees a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_meta <= 1'b0;
            z_s    <= 1'b0;
            stim_q <= 1'b0;
        end else begin
            z_meta <= dut_z;
            z_s    <= z_meta;
            stim_q <= stim_a;
        end
    end

    assign stim_edge = en && (stim_a != stim_q);
    // A good inverter drives z_s to ~stim_q, so equality is the failure case.
    assign mismatch  = (z_s == stim_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err_pulse <= 1'b0;
            check_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (stim_edge) begin
                            state <= S_SETTLE;
                            cnt   <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (stim_edge) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= S_CHECK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        cnt <= '0;
                        if (stim_edge) begin
                            state <= S_SETTLE;
                        end else begin
                            state <= S_IDLE;
                            if (check_cnt != CNT_MAX) begin
                                check_cnt <= check_cnt + 1'b1;
                            end
                            if (mismatch) begin
                                err_pulse <= 1'b1;
                                if (err_cnt != CNT_MAX) begin
                                    err_cnt <= err_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
            // Clear wins over a check completing in the same cycle.
            if (clr) begin
                check_cnt <= '0;
                err_cnt   <= '0;
            end
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign pass = (check_cnt != '0) && (err_cnt == '0);

endmodule
